// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution window sequencer.
package conv_pkg;

    localparam int SIZE_DEF      = 3;
    localparam int WIDTH_BIT_DEF = 8;

    typedef enum logic [2:0] {IDLE, FETCH, LAST, CONV, OUT, DONE} state_t;

    typedef logic [WIDTH_BIT_DEF-1:0] win_t [SIZE_DEF][SIZE_DEF];

endpackage

// File: rtl/conv_addr_gen.sv
// Maps window origin (row, col) and fetch index k to a row-major pixel
// address and the window cell that read k fills.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int SIZE   = SIZE_DEF,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = $clog2(IMG_W*IMG_H),
    parameter int RW     = $clog2(IMG_H),
    parameter int CW     = $clog2(IMG_W),
    parameter int KW     = $clog2(SIZE*SIZE+1),
    parameter int WW     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic [RW-1:0]     row,
    input  logic [CW-1:0]     col,
    input  logic [KW-1:0]     k,
    output logic [ADDR_W-1:0] addr,
    output logic [WW-1:0]     win_row,
    output logic [WW-1:0]     win_col
);

    localparam int AW1 = ADDR_W + 1;

    int unsigned     kr;
    int unsigned     kc;
    logic [AW1-1:0]  y;
    logic [AW1-1:0]  x;

    always_comb begin
        kr      = 32'(k) / SIZE;
        kc      = 32'(k) % SIZE;
        y       = AW1'(32'(row) + kr);
        x       = AW1'(32'(col) + kc);
        addr    = ADDR_W'(y * AW1'(IMG_W) + x);
        win_row = WW'(kr);
        win_col = WW'(kc);
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Scans an image in a single-port RAM with stride 1, loads each SIZE x SIZE
// window, fires the conv datapath and streams the tagged results.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int SIZE      = SIZE_DEF,
    parameter int WIDTH_BIT = WIDTH_BIT_DEF,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int ADDR_W    = $clog2(IMG_W*IMG_H)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     rd_en_o,
    output logic [ADDR_W-1:0]        rd_addr_o,
    input  logic [WIDTH_BIT-1:0]     rd_data_i,
    output logic [WIDTH_BIT-1:0]     win_o [SIZE][SIZE],
    output logic                     conv_ena_o,
    input  logic [WIDTH_BIT-1:0]     conv_res_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH_BIT-1:0]     out_data_o,
    output logic [$clog2(IMG_H)-1:0] out_row_o,
    output logic [$clog2(IMG_W)-1:0] out_col_o
);

    localparam int NWIN = SIZE * SIZE;
    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);
    localparam int KW   = $clog2(NWIN + 1);
    localparam int WW   = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(NWIN - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - SIZE);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - SIZE);

    state_t          state;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [KW-1:0]   k;

    logic [RW-1:0]     ag_row;
    logic [CW-1:0]     ag_col;
    logic [KW-1:0]     ag_k;
    logic [ADDR_W-1:0] ag_addr;
    logic [WW-1:0]     ag_win_row;
    logic [WW-1:0]     ag_win_col;

    // Window cell of the read on the bus now, and of the read whose data arrives now.
    logic [WW-1:0] cur_row;
    logic [WW-1:0] cur_col;
    logic [WW-1:0] pend_row;
    logic [WW-1:0] pend_col;
    logic          pend_v;

    // rd_addr_o is registered, so the generator sees the coordinates of the next read.
    always_comb begin
        ag_row = row;
        ag_col = col;
        ag_k   = k + KW'(1);
        case (state)
            IDLE: begin
                ag_row = '0;
                ag_col = '0;
                ag_k   = '0;
            end
            OUT: begin
                ag_k = '0;
                if (col != COL_LAST) begin
                    ag_col = col + CW'(1);
                end else begin
                    ag_col = '0;
                    ag_row = row + RW'(1);
                end
            end
            default: ;
        endcase
    end

    conv_addr_gen #(
        .SIZE   (SIZE),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .RW     (RW),
        .CW     (CW),
        .KW     (KW),
        .WW     (WW)
    ) u_addr_gen (
        .row     (ag_row),
        .col     (ag_col),
        .k       (ag_k),
        .addr    (ag_addr),
        .win_row (ag_win_row),
        .win_col (ag_win_col)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            k           <= '0;
            cur_row     <= '0;
            cur_col     <= '0;
            pend_row    <= '0;
            pend_col    <= '0;
            pend_v      <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            rd_en_o     <= 1'b0;
            rd_addr_o   <= '0;
            win_o       <= '{default: '0};
            conv_ena_o  <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_row_o   <= '0;
            out_col_o   <= '0;
        end else begin
            pend_v   <= rd_en_o;
            pend_row <= cur_row;
            pend_col <= cur_col;
            if (pend_v) begin
                win_o[pend_row][pend_col] <= rd_data_i;
            end

            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        row       <= '0;
                        col       <= '0;
                        k         <= '0;
                        busy_o    <= 1'b1;
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= ag_addr;
                        cur_row   <= ag_win_row;
                        cur_col   <= ag_win_col;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (k == K_LAST) begin
                        rd_en_o <= 1'b0;
                        state   <= LAST;
                    end else begin
                        k         <= ag_k;
                        rd_addr_o <= ag_addr;
                        cur_row   <= ag_win_row;
                        cur_col   <= ag_win_col;
                    end
                end
                LAST: begin
                    conv_ena_o <= 1'b1;
                    state      <= CONV;
                end
                CONV: begin
                    conv_ena_o  <= 1'b0;
                    out_valid_o <= 1'b1;
                    out_data_o  <= conv_res_i;
                    out_row_o   <= row;
                    out_col_o   <= col;
                    state       <= OUT;
                end
                OUT: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        k           <= '0;
                        if (col != COL_LAST || row != ROW_LAST) begin
                            row       <= ag_row;
                            col       <= ag_col;
                            rd_en_o   <= 1'b1;
                            rd_addr_o <= ag_addr;
                            cur_row   <= ag_win_row;
                            cur_col   <= ag_win_col;
                            state     <= FETCH;
                        end else begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench: a 4x4 and a 5x3 instance, each fed by a 1-cycle-latency
// pixel RAM and a window-sum conv datapath.
module tb_conv_window_ctrl;
    import conv_pkg::*;

    localparam int MAXC = 62;

    typedef struct packed {
        int sel;
        int all255;
        int stall;
        int sp1;
        int sp2;
        int rst;
        int n_res;
        logic [3:0][7:0] d;
        logic [3:0][7:0] r;
        logic [3:0][7:0] c;
        logic [3:0][7:0] cy;
        int n_done;
        int done_cyc;
        int n_valid;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, ready, all255;
    int   sel;

    // 4x4 instance
    logic       start_a, busy_a, done_a, rd_en_a, ena_a, valid_a;
    logic [3:0] rd_addr_a;
    logic [7:0] rd_data_a, res_a, data_a;
    logic [7:0] win_a [3][3];
    logic [1:0] row_a, col_a;
    int         sa;

    // 5x3 instance
    logic       start_b, busy_b, done_b, rd_en_b, ena_b, valid_b;
    logic [3:0] rd_addr_b;
    logic [7:0] rd_data_b, res_b, data_b;
    logic [7:0] win_b [3][3];
    logic [1:0] row_b;
    logic [2:0] col_b;
    int         sb;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);

    conv_window_ctrl #(.SIZE(3), .WIDTH_BIT(8), .IMG_W(4), .IMG_H(4)) dut_a (
        .clock(clk), .reset(reset), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .rd_en_o(rd_en_a), .rd_addr_o(rd_addr_a), .rd_data_i(rd_data_a), .win_o(win_a),
        .conv_ena_o(ena_a), .conv_res_i(res_a), .out_valid_o(valid_a), .out_ready_i(ready),
        .out_data_o(data_a), .out_row_o(row_a), .out_col_o(col_a)
    );

    conv_window_ctrl #(.SIZE(3), .WIDTH_BIT(8), .IMG_W(5), .IMG_H(3)) dut_b (
        .clock(clk), .reset(reset), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .rd_en_o(rd_en_b), .rd_addr_o(rd_addr_b), .rd_data_i(rd_data_b), .win_o(win_b),
        .conv_ena_o(ena_b), .conv_res_i(res_b), .out_valid_o(valid_b), .out_ready_i(ready),
        .out_data_o(data_b), .out_row_o(row_b), .out_col_o(col_b)
    );

    // Pixel value equals its row-major address, or 255 everywhere.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= all255 ? 8'hFF : {4'd0, rd_addr_a};
        if (rd_en_b) rd_data_b <= {4'd0, rd_addr_b};
    end

    always_comb begin
        sa = 0;
        foreach (win_a[i, j]) sa += int'(win_a[i][j]);
        sb = 0;
        foreach (win_b[i, j]) sb += int'(win_b[i][j]);
    end
    assign res_a = 8'(sa);
    assign res_b = 8'(sb);

    logic m_valid, m_rden, m_ena, m_busy, m_done, winor;
    int   m_addr, m_data, m_row, m_col;

    always_comb begin
        if (sel == 0) begin
            m_valid = valid_a; m_rden = rd_en_a; m_ena = ena_a; m_busy = busy_a; m_done = done_a;
            m_addr = int'(rd_addr_a); m_data = int'(data_a); m_row = int'(row_a); m_col = int'(col_a);
        end else begin
            m_valid = valid_b; m_rden = rd_en_b; m_ena = ena_b; m_busy = busy_b; m_done = done_b;
            m_addr = int'(rd_addr_b); m_data = int'(data_b); m_row = int'(row_b); m_col = int'(col_b);
        end
        winor = 1'b0;
        foreach (win_a[i, j]) winor |= (win_a[i][j] != 8'd0);
    end

    int checks = 0;
    int errors = 0;

    int log_valid[64], log_rden[64], log_addr[64], log_data[64];
    int log_ena[64], log_busy[64], log_winor[64];
    int got_d[8], got_r[8], got_c[8], got_cy[8];
    int n_got, n_done, first_done, n_ena, n_valid;

    vec_t tv[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_scan(input vec_t v);
        sel    = v.sel;
        all255 = (v.all255 != 0);
        start  = 1'b0;
        ready  = 1'b1;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_got = 0; n_done = 0; first_done = -1; n_ena = 0; n_valid = 0;
        for (int c = 0; c < MAXC; c++) begin
            start = (c == 0) || (c == v.sp1) || (c == v.sp2);
            reset = (c == v.rst);
            ready = !(c >= 12 && c < 12 + v.stall);
            @(negedge clk);
            log_valid[c] = int'(m_valid);
            log_rden[c]  = int'(m_rden);
            log_addr[c]  = m_addr;
            log_data[c]  = m_data;
            log_ena[c]   = int'(m_ena);
            log_busy[c]  = int'(m_busy);
            log_winor[c] = int'(winor);
            if (m_ena) n_ena++;
            if (m_valid) n_valid++;
            if (m_done) begin
                if (n_done == 0) first_done = c;
                n_done++;
            end
            if (m_valid && ready && n_got < 8) begin
                got_d[n_got]  = m_data;
                got_r[n_got]  = m_row;
                got_c[n_got]  = m_col;
                got_cy[n_got] = c;
                n_got++;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        int exp_addr[9];
        int bad;

        exp_addr = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

        // sel all255 stall sp1 sp2 rst n  data  row  col  handshake-cycle  ndone donecyc nvalid
        tv[0] = '{0, 0, 0, -1, -1, -1, 4, {8'd90, 8'd81, 8'd54, 8'd45}, {8'd1, 8'd1, 8'd0, 8'd0},
                  {8'd1, 8'd0, 8'd1, 8'd0}, {8'd48, 8'd36, 8'd24, 8'd12}, 1, 49, 4};
        tv[1] = '{0, 0, 5, -1, -1, -1, 4, {8'd90, 8'd81, 8'd54, 8'd45}, {8'd1, 8'd1, 8'd0, 8'd0},
                  {8'd1, 8'd0, 8'd1, 8'd0}, {8'd53, 8'd41, 8'd29, 8'd17}, 1, 54, 9};
        tv[2] = '{0, 0, 0, 5, 12, -1, 4, {8'd90, 8'd81, 8'd54, 8'd45}, {8'd1, 8'd1, 8'd0, 8'd0},
                  {8'd1, 8'd0, 8'd1, 8'd0}, {8'd48, 8'd36, 8'd24, 8'd12}, 1, 49, 4};
        tv[3] = '{0, 0, 0, -1, -1, 20, 1, {8'd0, 8'd0, 8'd0, 8'd45}, {8'd0, 8'd0, 8'd0, 8'd0},
                  {8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd12}, 0, -1, 1};
        tv[4] = tv[0];
        tv[5] = '{1, 0, 0, -1, -1, -1, 3, {8'd0, 8'd72, 8'd63, 8'd54}, {8'd0, 8'd0, 8'd0, 8'd0},
                  {8'd0, 8'd2, 8'd1, 8'd0}, {8'd0, 8'd36, 8'd24, 8'd12}, 1, 37, 3};
        tv[6] = '{0, 1, 0, -1, -1, -1, 4, {8'd247, 8'd247, 8'd247, 8'd247}, {8'd1, 8'd1, 8'd0, 8'd0},
                  {8'd1, 8'd0, 8'd1, 8'd0}, {8'd48, 8'd36, 8'd24, 8'd12}, 1, 49, 4};

        // Reset state
        sel = 0; all255 = 1'b0; start = 1'b0; ready = 1'b1; reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_rd_en", int'(rd_en_a), 0);
        chk("rst_rd_addr", int'(rd_addr_a), 0);
        chk("rst_conv_ena", int'(ena_a), 0);
        chk("rst_out_valid", int'(valid_a), 0);
        chk("rst_out_data", int'(data_a), 0);
        chk("rst_out_row", int'(row_a), 0);
        chk("rst_out_col", int'(col_a), 0);
        chk("rst_win", int'(winor), 0);

        for (int i = 0; i < 7; i++) begin
            run_scan(tv[i]);
            chk($sformatf("v%0d_n_results", i), n_got, tv[i].n_res);
            for (int j = 0; j < tv[i].n_res; j++) begin
                chk($sformatf("v%0d_r%0d_data", i, j), (j < n_got) ? got_d[j] : -1, int'(tv[i].d[j]));
                chk($sformatf("v%0d_r%0d_row", i, j), (j < n_got) ? got_r[j] : -1, int'(tv[i].r[j]));
                chk($sformatf("v%0d_r%0d_col", i, j), (j < n_got) ? got_c[j] : -1, int'(tv[i].c[j]));
                chk($sformatf("v%0d_r%0d_cycle", i, j), (j < n_got) ? got_cy[j] : -1, int'(tv[i].cy[j]));
            end
            chk($sformatf("v%0d_done_pulses", i), n_done, tv[i].n_done);
            chk($sformatf("v%0d_done_cycle", i), first_done, tv[i].done_cyc);
            chk($sformatf("v%0d_conv_ena_cycles", i), n_ena, tv[i].n_res);
            chk($sformatf("v%0d_valid_cycles", i), n_valid, tv[i].n_valid);
        end

        // First-window address sequence and busy envelope
        run_scan(tv[0]);
        chk("addr_c0_rd_en", log_rden[0], 0);
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("addr_c%0d_rd_en", c), log_rden[c], 1);
            chk($sformatf("addr_c%0d", c), log_addr[c], exp_addr[c-1]);
        end
        chk("addr_c10_rd_en", log_rden[10], 0);
        chk("busy_c0", log_busy[0], 0);
        chk("busy_c1", log_busy[1], 1);
        chk("busy_c49", log_busy[49], 1);
        chk("busy_c50", log_busy[50], 0);

        // Backpressure holds the result and issues no reads
        run_scan(tv[1]);
        for (int c = 12; c <= 17; c++) begin
            chk($sformatf("stall_c%0d_valid", c), log_valid[c], 1);
            chk($sformatf("stall_c%0d_data", c), log_data[c], 45);
            chk($sformatf("stall_c%0d_rd_en", c), log_rden[c], 0);
        end

        // Mid-scan reset clears state the next cycle
        run_scan(tv[3]);
        chk("pre_rst_win_loaded", log_winor[20], 1);
        chk("post_rst_busy", log_busy[21], 0);
        chk("post_rst_valid", log_valid[21], 0);
        chk("post_rst_ena", log_ena[21], 0);
        chk("post_rst_win", log_winor[21], 0);

        // conv_ena is a single-cycle pulse per window
        run_scan(tv[6]);
        bad = 0;
        for (int c = 0; c < MAXC - 1; c++) begin
            if (log_ena[c] != 0 && log_ena[c+1] != 0) bad++;
        end
        chk("ena_back_to_back", bad, 0);
        chk("ena_c11", log_ena[11], 1);
        chk("ena_c23", log_ena[23], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
